// File: rtl/card_dealer.sv
`default_nettype none
// ============================================================================
// Module   : card_dealer
// Purpose  : Deck responder for the blackjack FSM. On a request it deals one
//            card from a 52-card deck and never repeats a card until the deck
//            is reshuffled. A free-running Galois LFSR picks a start index,
//            and a linear probe then walks forward to the next unused card.
//
// Ports    : clk          in   system clock, rising edge
//            rst_n        in   asynchronous active-low reset
//            req          in   card request level, held until ack
//            shuffle      in   pulse; return all 52 cards to the deck
//            ack          out  one-cycle pulse; card outputs valid this cycle
//            card_value   out  [3:0] 1=A .. 11=J, 12=Q, 13=K, 0=no card
//            card_symbol  out  [1:0] suit 0..3
//            deck_empty   out  high when cards_left == 0
//            cards_left   out  [5:0] cards remaining, 0..52
//            busy         out  high while in PICK, PROBE or ACK
//
// Revision : 1.0 - initial release
// ============================================================================
module card_dealer #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic       shuffle,
    output logic       ack,
    output logic [3:0] card_value,
    output logic [1:0] card_symbol,
    output logic       deck_empty,
    output logic [5:0] cards_left,
    output logic       busy
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [15:0] c_lfsr_mask  = 16'hB400;
    localparam logic [5:0]  c_deck_size  = 6'd52;
    localparam logic [5:0]  c_last_idx   = 6'd51;

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PICK     = 3'd1,
        S_PROBE    = 3'd2,
        S_ACK      = 3'd3,
        S_WAIT_LOW = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [15:0] r_lfsr;
    logic [51:0] r_used;          // one bit per card, 1 = already dealt
    logic [5:0]  r_idx;           // current probe position, always 0..51
    logic [5:0]  r_cards_left;
    logic [3:0]  r_card_value;
    logic [1:0]  r_card_symbol;
    logic        r_shuffle_pend;  // shuffle seen outside IDLE, not yet applied

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [15:0] w_lfsr_next;
    logic [5:0]  w_lfsr_low;
    logic [5:0]  w_pick_idx;
    logic [5:0]  w_probe_next;
    logic        w_hit;
    logic        w_do_shuffle;
    logic [1:0]  w_symbol;
    logic [3:0]  w_base_low;
    logic [3:0]  w_value;

    // Galois right-shift LFSR; the feedback mask is applied when the bit
    // shifted out is 1. It runs in every state so that the start index depends
    // on how long the requester waited between cards.
    assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? c_lfsr_mask : 16'h0000);

    // Fold the 6-bit LFSR slice into 0..51. Values 52..63 map onto 0..11,
    // a small bias that is acceptable for a game deck.
    assign w_lfsr_low = r_lfsr[5:0];
    assign w_pick_idx = (w_lfsr_low >= c_deck_size) ? (w_lfsr_low - c_deck_size)
                                                    : w_lfsr_low;

    // Linear probe wraps from the last card back to the first.
    assign w_probe_next = (r_idx == c_last_idx) ? 6'd0 : (r_idx + 6'd1);

    assign w_hit        = ~r_used[r_idx];
    assign w_do_shuffle = shuffle | r_shuffle_pend;

    // Index to card decode: symbol = idx/13, value = idx - 13*symbol + 1.
    // The value always lies in 1..13, so the subtraction is done modulo 16
    // on the low four bits only; the suit bases 0/13/26/39 reduce to
    // 0/13/10/7 in four bits.
    always_comb begin
        w_symbol   = 2'd0;
        w_base_low = 4'd0;
        if (r_idx < 6'd13) begin
            w_symbol   = 2'd0;
            w_base_low = 4'd0;
        end else if (r_idx < 6'd26) begin
            w_symbol   = 2'd1;
            w_base_low = 4'd13;
        end else if (r_idx < 6'd39) begin
            w_symbol   = 2'd2;
            w_base_low = 4'd10;
        end else begin
            w_symbol   = 2'd3;
            w_base_low = 4'd7;
        end
    end

    assign w_value = r_idx[3:0] - w_base_low + 4'd1;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                // A shuffle is serviced in place; a request held through it
                // is picked up on the following IDLE cycle.
                if (w_do_shuffle) begin
                    w_state_next = S_IDLE;
                end else if (req) begin
                    w_state_next = S_PICK;
                end
            end
            S_PICK: begin
                if (r_cards_left == 6'd0) begin
                    w_state_next = S_ACK;
                end else begin
                    w_state_next = S_PROBE;
                end
            end
            S_PROBE: begin
                // Always terminates: at least one card is still unused.
                if (w_hit) begin
                    w_state_next = S_ACK;
                end
            end
            S_ACK: begin
                w_state_next = S_WAIT_LOW;
            end
            S_WAIT_LOW: begin
                if (!req) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr         <= SEED;
            r_used         <= '0;
            r_idx          <= 6'd0;
            r_cards_left   <= c_deck_size;
            r_card_value   <= 4'd0;
            r_card_symbol  <= 2'd0;
            r_shuffle_pend <= 1'b0;
        end else begin
            r_lfsr <= w_lfsr_next;

            // A shuffle arriving mid-transaction is remembered and applied
            // once the dealer is back in IDLE, so the card in flight is
            // never disturbed.
            if (shuffle && (r_state != S_IDLE)) begin
                r_shuffle_pend <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_do_shuffle) begin
                        r_used         <= '0;
                        r_cards_left   <= c_deck_size;
                        r_shuffle_pend <= 1'b0;
                    end
                end
                S_PICK: begin
                    r_idx <= w_pick_idx;
                    if (r_cards_left == 6'd0) begin
                        r_card_value  <= 4'd0;
                        r_card_symbol <= 2'd0;
                    end
                end
                S_PROBE: begin
                    if (w_hit) begin
                        r_used[r_idx] <= 1'b1;
                        r_card_value  <= w_value;
                        r_card_symbol <= w_symbol;
                    end else begin
                        r_idx <= w_probe_next;
                    end
                end
                S_ACK: begin
                    // The count drops as the ack pulse ends, so deck_empty
                    // rises in the cycle after the last card's ack. A value
                    // of 0 marks an empty-deck response that dealt nothing.
                    if (r_card_value != 4'd0) begin
                        r_cards_left <= r_cards_left - 6'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign ack         = (r_state == S_ACK);
    assign busy        = (r_state == S_PICK) || (r_state == S_PROBE) || (r_state == S_ACK);
    assign card_value  = r_card_value;
    assign card_symbol = r_card_symbol;
    assign cards_left  = r_cards_left;
    assign deck_empty  = (r_cards_left == 6'd0);

endmodule
`default_nettype wire

// File: tb/tb_card_dealer.sv
`default_nettype none
// ============================================================================
// Module   : tb_card_dealer
// Purpose  : Directed self-checking bench for card_dealer. Each scenario task
//            drives its own stimulus and compares against hand-derived values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_card_dealer;

    logic       clk;
    logic       rst_n;
    logic       req;
    logic       shuffle;
    logic       ack;
    logic [3:0] card_value;
    logic [1:0] card_symbol;
    logic       deck_empty;
    logic [5:0] cards_left;
    logic       busy;

    int         checks;
    int         errors;
    logic [3:0] first_value;
    logic [1:0] first_symbol;
    logic [51:0] seen;

    card_dealer #(
        .SEED(16'hACE1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .shuffle    (shuffle),
        .ack        (ack),
        .card_value (card_value),
        .card_symbol(card_symbol),
        .deck_empty (deck_empty),
        .cards_left (cards_left),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reset is released on a falling edge so every run starts with the same
    // clock phase; returns 1 time unit after the first rising edge after.
    task automatic do_reset();
        rst_n   = 1'b0;
        req     = 1'b0;
        shuffle = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Raise req, wait (bounded) for ack, capture the card, release and let
    // the dealer return to IDLE. lat = rising edges from req to ack.
    task automatic request_card(output logic [3:0] v, output logic [1:0] s,
                                output int lat, output bit got);
        req = 1'b1;
        lat = 0;
        got = 1'b0;
        v   = 4'd0;
        s   = 2'd0;
        while (!got && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
            if (ack) begin
                got = 1'b1;
                v   = card_value;
                s   = card_symbol;
            end
        end
        req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", ack); end
        checks++; if (card_value !== 4'd0) begin errors++; $display("FAIL reset_value: got %0d expected 0", card_value); end
        checks++; if (card_symbol !== 2'd0) begin errors++; $display("FAIL reset_symbol: got %0d expected 0", card_symbol); end
        checks++; if (deck_empty !== 1'b0) begin errors++; $display("FAIL reset_deck_empty: got %b expected 0", deck_empty); end
        checks++; if (cards_left !== 6'd52) begin errors++; $display("FAIL reset_cards_left: got %0d expected 52", cards_left); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_first_card();
        int lat;
        bit got;
        int extra;
        req = 1'b1;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
            if (ack) begin
                got          = 1'b1;
                first_value  = card_value;
                first_symbol = card_symbol;
            end
        end
        checks++; if (!got) begin errors++; $display("FAIL first_ack_timeout: got no ack expected ack within 54"); end
        // Fresh deck: the first probe always hits, so ack follows 3 edges.
        checks++; if (lat != 3) begin errors++; $display("FAIL first_latency: got %0d expected 3", lat); end
        checks++; if (first_value < 4'd1 || first_value > 4'd13) begin errors++; $display("FAIL first_value_range: got %0d expected 1..13", first_value); end
        @(posedge clk);
        #1;
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL first_ack_width: got %b expected 0", ack); end
        checks++; if (cards_left !== 6'd51) begin errors++; $display("FAIL first_cards_left: got %0d expected 51", cards_left); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL first_busy_after_ack: got %b expected 0", busy); end
        extra = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (ack) extra++;
        end
        checks++; if (extra != 0) begin errors++; $display("FAIL held_req_extra_ack: got %0d expected 0", extra); end
        req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        seen = '0;
        seen[int'(first_symbol) * 13 + int'(first_value) - 1] = 1'b1;
    endtask

    task automatic test_deal_all();
        logic [3:0] v;
        logic [1:0] s;
        int lat;
        bit got;
        int idx;
        for (int n = 1; n < 52; n++) begin
            request_card(v, s, lat, got);
            checks++; if (!got) begin errors++; $display("FAIL deal_ack_timeout: card %0d got no ack expected ack", n + 1); end
            checks++; if (v < 4'd1 || v > 4'd13) begin errors++; $display("FAIL deal_value_range: card %0d got %0d expected 1..13", n + 1, v); end
            idx = int'(s) * 13 + int'(v) - 1;
            if (idx >= 0 && idx < 52) begin
                checks++; if (seen[idx]) begin errors++; $display("FAIL deal_duplicate: card %0d got repeat value %0d symbol %0d expected unused card", n + 1, v, s); end
                seen[idx] = 1'b1;
            end
            checks++; if (int'(cards_left) != 52 - (n + 1)) begin errors++; $display("FAIL deal_cards_left: got %0d expected %0d", cards_left, 52 - (n + 1)); end
        end
        checks++; if (seen !== {52{1'b1}}) begin errors++; $display("FAIL deal_all_distinct: got %h expected all 52 cards", seen); end
        checks++; if (cards_left !== 6'd0) begin errors++; $display("FAIL depleted_cards_left: got %0d expected 0", cards_left); end
        checks++; if (deck_empty !== 1'b1) begin errors++; $display("FAIL depleted_deck_empty: got %b expected 1", deck_empty); end
    endtask

    task automatic test_empty_request();
        logic [3:0] v;
        logic [1:0] s;
        int lat;
        bit got;
        request_card(v, s, lat, got);
        checks++; if (!got) begin errors++; $display("FAIL empty_ack_timeout: got no ack expected ack"); end
        // Empty deck skips the probe, so the ack is no later than a hit.
        checks++; if (lat < 2 || lat > 3) begin errors++; $display("FAIL empty_latency: got %0d expected 2..3", lat); end
        checks++; if (v !== 4'd0) begin errors++; $display("FAIL empty_value: got %0d expected 0", v); end
        checks++; if (s !== 2'd0) begin errors++; $display("FAIL empty_symbol: got %0d expected 0", s); end
        checks++; if (cards_left !== 6'd0) begin errors++; $display("FAIL empty_cards_left: got %0d expected 0", cards_left); end
        checks++; if (deck_empty !== 1'b1) begin errors++; $display("FAIL empty_deck_empty: got %b expected 1", deck_empty); end
    endtask

    task automatic test_shuffle_with_req();
        int lat;
        bit got;
        logic [3:0] v;
        req     = 1'b1;
        shuffle = 1'b1;
        @(posedge clk);
        #1;
        shuffle = 1'b0;
        checks++; if (cards_left !== 6'd52) begin errors++; $display("FAIL shuf_req_cards_left: got %0d expected 52", cards_left); end
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL shuf_req_ack_early: got %b expected 0", ack); end
        checks++; if (deck_empty !== 1'b0) begin errors++; $display("FAIL shuf_req_deck_empty: got %b expected 0", deck_empty); end
        lat = 0;
        got = 1'b0;
        v   = 4'd0;
        while (!got && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
            if (ack) begin got = 1'b1; v = card_value; end
        end
        req = 1'b0;
        checks++; if (!got) begin errors++; $display("FAIL shuf_req_ack_timeout: got no ack expected ack"); end
        checks++; if (v < 4'd1 || v > 4'd13) begin errors++; $display("FAIL shuf_req_value: got %0d expected 1..13", v); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (cards_left !== 6'd51) begin errors++; $display("FAIL shuf_req_cards_after: got %0d expected 51", cards_left); end
    endtask

    task automatic test_shuffle_idle();
        shuffle = 1'b1;
        @(posedge clk);
        #1;
        shuffle = 1'b0;
        checks++; if (cards_left !== 6'd52) begin errors++; $display("FAIL shuf_idle_cards_left: got %0d expected 52", cards_left); end
        checks++; if (deck_empty !== 1'b0) begin errors++; $display("FAIL shuf_idle_deck_empty: got %b expected 0", deck_empty); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL shuf_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_shuffle_probe();
        int lat;
        bit got;
        logic [3:0] v;
        req = 1'b1;
        @(posedge clk);   // IDLE -> PICK
        #1;
        @(posedge clk);   // PICK -> PROBE
        #1;
        shuffle = 1'b1;
        lat = 2;
        got = 1'b0;
        v   = 4'd0;
        while (!got && lat < 60) begin
            @(posedge clk);
            #1;
            shuffle = 1'b0;
            lat++;
            if (ack) begin got = 1'b1; v = card_value; end
        end
        req = 1'b0;
        checks++; if (!got) begin errors++; $display("FAIL shuf_probe_ack_timeout: got no ack expected ack"); end
        checks++; if (v < 4'd1 || v > 4'd13) begin errors++; $display("FAIL shuf_probe_value: got %0d expected 1..13", v); end
        @(posedge clk);   // ACK -> WAIT_LOW
        #1;
        checks++; if (cards_left !== 6'd51) begin errors++; $display("FAIL shuf_probe_wait_low: got %0d expected 51", cards_left); end
        @(posedge clk);   // WAIT_LOW -> IDLE
        #1;
        checks++; if (cards_left !== 6'd51) begin errors++; $display("FAIL shuf_probe_idle_entry: got %0d expected 51", cards_left); end
        @(posedge clk);   // pending shuffle applied in IDLE
        #1;
        checks++; if (cards_left !== 6'd52) begin errors++; $display("FAIL shuf_probe_applied: got %0d expected 52", cards_left); end
    endtask

    task automatic test_async_reset();
        logic [3:0] v;
        logic [1:0] s;
        int lat;
        bit got;
        request_card(v, s, lat, got);
        checks++; if (!got) begin errors++; $display("FAIL areset_pre1_timeout: got no ack expected ack"); end
        request_card(v, s, lat, got);
        checks++; if (!got) begin errors++; $display("FAIL areset_pre2_timeout: got no ack expected ack"); end
        checks++; if (cards_left !== 6'd50) begin errors++; $display("FAIL areset_pre_cards_left: got %0d expected 50", cards_left); end
        req = 1'b1;
        @(posedge clk);   // IDLE -> PICK
        @(posedge clk);   // PICK -> PROBE
        #2;
        rst_n = 1'b0;     // between clock edges
        #1;
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL areset_ack: got %b expected 0", ack); end
        checks++; if (cards_left !== 6'd52) begin errors++; $display("FAIL areset_cards_left: got %0d expected 52", cards_left); end
        checks++; if (card_value !== 4'd0) begin errors++; $display("FAIL areset_value: got %0d expected 0", card_value); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy: got %b expected 0", busy); end
        // Replay the fresh-run timing: same release phase, req right after.
        do_reset();
        request_card(v, s, lat, got);
        checks++; if (!got) begin errors++; $display("FAIL areset_replay_timeout: got no ack expected ack"); end
        checks++; if (lat != 3) begin errors++; $display("FAIL areset_replay_latency: got %0d expected 3", lat); end
        checks++; if (v !== first_value || s !== first_symbol) begin
            errors++;
            $display("FAIL areset_replay_card: got value %0d symbol %0d expected value %0d symbol %0d", v, s, first_value, first_symbol);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        do_reset();
        test_reset();
        test_first_card();
        test_deal_all();
        test_empty_request();
        test_shuffle_with_req();
        test_shuffle_idle();
        test_shuffle_probe();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
